// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: fetch, decode, execute, memory, writeback.
// Holds the IR, drives datapath controls, counts retirements, traps faults.
module multicycle_control_unit #(
  parameter int unsigned BUS_TIMEOUT = 255,
  parameter int unsigned INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 instrReq,
  input  logic                 instrReady,
  input  logic [31:0]          instrRData,
  output logic [31:0]          instrCode,
  output logic                 pcEn,
  output logic                 regFileWe,
  output logic                 aluSrcMuxSel,
  output logic [3:0]           aluControl,
  output logic [2:0]           RFWDSrcMuxSel,
  output logic                 branch,
  output logic                 jal,
  output logic                 busReq,
  output logic                 busWe,
  output logic [2:0]           busSize,
  input  logic                 busReady,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  localparam int TW =
    (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST =
    (BUS_TIMEOUT == 0) ? '0 : TW'(BUS_TIMEOUT - 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  localparam logic [2:0] WD_ALU   = 3'd0;
  localparam logic [2:0] WD_BUS   = 3'd1;
  localparam logic [2:0] WD_IMM   = 3'd2;
  localparam logic [2:0] WD_PCIMM = 3'd3;
  localparam logic [2:0] WD_PC4   = 3'd4;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM_LD,
    S_MEM_ST,
    S_TRAP
  } state_e;

  state_e                 state_q, state_d;
  logic [31:0]            ir_q, ir_d;
  logic [TW-1:0]          cnt_q, cnt_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b;

  logic is_r, is_i, is_ld, is_st, is_br;
  logic is_lui, is_aui, is_jal, is_jalr;
  logic legal;

  logic [3:0] ex_alu;
  logic       ex_src;
  logic [2:0] ex_wd;
  logic       ex_wb;
  logic       ex_retire;

  logic bus_done;
  logic timeout_hit;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign f7b    = ir_q[30];

  assign is_r    = (opcode == OP_R);
  assign is_i    = (opcode == OP_I);
  assign is_ld   = (opcode == OP_LOAD);
  assign is_st   = (opcode == OP_STORE);
  assign is_br   = (opcode == OP_BR);
  assign is_lui  = (opcode == OP_LUI);
  assign is_aui  = (opcode == OP_AUIPC);
  assign is_jal  = (opcode == OP_JAL);
  assign is_jalr = (opcode == OP_JALR);

  assign legal = is_r | is_i | is_ld | is_st | is_br |
                 is_lui | is_aui | is_jal | is_jalr;

  // Execute-stage controls; loads/stores keep ADD+imm through MEM.
  always_comb begin
    ex_alu = ALU_ADD;
    ex_src = 1'b0;
    ex_wd  = WD_ALU;
    ex_wb  = 1'b0;
    unique case (1'b1)
      is_r: begin
        ex_alu = {f7b, funct3};
        ex_wb  = 1'b1;
      end
      is_i: begin
        ex_src = 1'b1;
        ex_alu = (funct3 == 3'b101) ? {f7b, funct3}
                                    : {1'b0, funct3};
        ex_wb  = 1'b1;
      end
      is_lui: begin
        ex_wd = WD_IMM;
        ex_wb = 1'b1;
      end
      is_aui: begin
        ex_wd = WD_PCIMM;
        ex_wb = 1'b1;
      end
      is_jal: begin
        ex_wd = WD_PC4;
        ex_wb = 1'b1;
      end
      is_jalr: begin
        ex_wd  = WD_PC4;
        ex_src = 1'b1;
        ex_wb  = 1'b1;
      end
      is_br: begin
        ex_alu = {1'b0, funct3};
      end
      is_ld, is_st: begin
        ex_src = 1'b1;
      end
      default: ;
    endcase
  end

  assign ex_retire   = ~(is_ld | is_st);
  assign bus_done    = busReady & ~reset;
  assign timeout_hit = (BUS_TIMEOUT != 0) &&
                       (cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      cnt_q     <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_FETCH: begin
        if (instrReady) begin
          ir_d    = instrRData;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        cnt_d = '0;
        if (is_ld) begin
          state_d = S_MEM_LD;
        end else if (is_st) begin
          state_d = S_MEM_ST;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM_LD, S_MEM_ST: begin
        if (busReady) begin
          state_d = S_FETCH;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_TRAP: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    instrReq      = 1'b0;
    pcEn          = 1'b0;
    regFileWe     = 1'b0;
    aluSrcMuxSel  = 1'b0;
    aluControl    = ALU_ADD;
    RFWDSrcMuxSel = WD_ALU;
    branch        = 1'b0;
    jal           = 1'b0;
    busReq        = 1'b0;
    busWe         = 1'b0;
    busSize       = 3'b000;
    unique case (state_q)
      S_FETCH: begin
        instrReq = 1'b1;
      end
      S_EXEC: begin
        aluControl    = ex_alu;
        aluSrcMuxSel  = ex_src;
        RFWDSrcMuxSel = ex_wd;
        branch        = is_br;
        jal           = is_jal | is_jalr;
        pcEn          = ex_retire & ~reset;
        regFileWe     = ex_wb & ~reset;
      end
      S_MEM_LD: begin
        busReq        = 1'b1;
        busSize       = funct3;
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = WD_BUS;
        pcEn          = bus_done;
        regFileWe     = bus_done;
      end
      S_MEM_ST: begin
        busReq       = 1'b1;
        busWe        = 1'b1;
        busSize      = funct3;
        aluSrcMuxSel = 1'b1;
        pcEn         = bus_done;
      end
      default: ;
    endcase
  end

  assign instret_d = instret_q + INSTRET_W'(pcEn);

  assign instrCode = ir_q;
  assign illegal   = (state_q == S_TRAP);
  assign instret   = instret_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle sequencer for the RV32I datapath: fetches an instruction over a ready/request handshake and holds it in an internal instruction register (IR).
- Walks each instruction through FETCH/DECODE/EXECUTE/MEM/WB states and drives every datapath control input, including a PC-enable.
- The datapath is thereby shared with a wait-state data bus instead of running single-cycle.
- Also tracks retired instructions and flags illegal opcodes and bus timeouts.

Parameters:
BUS_TIMEOUT, 255, max cycles busReq may wait for busReady before trapping (0 = never time out)
INSTRET_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
instrReq  output  1  instruction fetch request
instrReady  input  1  fetch data valid this cycle
instrRData  input  32  fetched instruction word
instrCode  output  32  IR contents, drives datapath decode/immExtend/RF addresses
pcEn  output  1  PC register load enable
regFileWe  output  1  register file write enable
aluSrcMuxSel  output  1  0 = rs2, 1 = immediate
aluControl  output  4  ALU operation code
RFWDSrcMuxSel  output  3  0 ALU result, 1 bus read data, 2 imm (LUI), 3 PC+imm (AUIPC), 4 PC+4 (JAL/JALR)
branch  output  1  conditional branch qualifier
jal  output  1  unconditional jump (JAL and JALR)
busReq  output  1  data bus request
busWe  output  1  data bus write (store)
busSize  output  3  IR funct3 during bus access
busReady  input  1  data bus access complete
illegal  output  1  sticky trap flag: illegal opcode or bus timeout
instret  output  INSTRET_W  retired instruction count

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is synchronous and active-high; it is sampled only on the rising edge of clk.
  - On reset, including mid-instruction: state=FETCH, IR=0, instret=0, illegal=0, timeout counter=0.
  - All control outputs are 0 in the cycle after reset; instrReq is 1 in FETCH.
- Output timing: all control outputs are combinational from state+IR; no output depends combinationally on instrReady/busReady except pcEn/regFileWe in MEM states.
- FETCH:
  - instrReq=1, all other controls 0.
  - On instrReady: IR<=instrRData, go to DECODE.
  - Otherwise hold.
- DECODE:
  - One cycle, controls 0.
  - Opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111} -> TRAP.
  - Otherwise -> EXECUTE.
- EXECUTE:
  - aluControl and aluSrcMuxSel held stable from this state through retirement.
  - R-type (0110011): aluControl={IR[30],funct3}, aluSrcMuxSel=0, RFWDSrcMuxSel=0.
  - I-ALU (0010011): aluSrcMuxSel=1; aluControl={IR[30],funct3} only for funct3=101, else {0,funct3}.
  - LUI: sel 2. AUIPC: sel 3.
  - JAL: jal=1, sel 4.
  - JALR: jal=1, sel 4, aluSrcMuxSel=1, aluControl=ADD(0000).
  - For R-type, I-ALU, LUI, AUIPC, JAL and JALR: regFileWe=1, pcEn=1, next FETCH.
  - B-type (1100011): branch=1, aluSrcMuxSel=0, aluControl={0,funct3}, pcEn=1, regFileWe=0, next FETCH.
  - Load (0000011): aluSrcMuxSel=1, aluControl=ADD, next MEM_LD.
  - Store (0100011): aluSrcMuxSel=1, aluControl=ADD, next MEM_ST.
- ALU encoding (aluControl): ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- MEM_ST:
  - busReq=1, busWe=1, busSize=funct3.
  - On busReady: pcEn=1 same cycle, next FETCH.
- MEM_LD:
  - busReq=1, busWe=0.
  - On busReady: regFileWe=1, RFWDSrcMuxSel=1, pcEn=1 same cycle, next FETCH.
- Bus timeout:
  - Counter clears on entering a MEM state and increments each waiting cycle.
  - If BUS_TIMEOUT!=0 and the count reaches BUS_TIMEOUT without busReady -> TRAP, no PC/RF update.
- TRAP: illegal=1, all controls 0, instrReq=0; held until reset.
- pcEn invariants:
  - High exactly one cycle per retired instruction.
  - regFileWe is never high without pcEn in the same cycle.
- instret: increments on each pcEn cycle; wraps modulo 2^INSTRET_W.
- Latency, zero wait states:
  - ALU, branch, jump, LUI and AUIPC: 3 cycles.
  - Load and store: 4 cycles.
  - Each fetch wait state or bus wait state adds 1 cycle.
- Simultaneous events: reset dominates everything, including busReady or instrReady in the same cycle.

Test Plan:
- instrReady=1, IR 0x002081B3 (add x3,x1,x2) -> FETCH, DECODE, EXECUTE with aluControl=0000, aluSrcMuxSel=0, RFWDSrcMuxSel=0, regFileWe=pcEn=1 in cycle 3; instret 0->1.
- 0x00002283 (lw x5,0(x0)), busReady delayed 2 cycles -> busReq=1, busWe=0 for 3 cycles; in the busReady cycle regFileWe=pcEn=1, RFWDSrcMuxSel=1; total 6 cycles.
- 0x00202223 (sw x2,4(x0)) -> busReq=busWe=1, busSize=010, aluSrcMuxSel=1; regFileWe stays 0; pcEn pulses once on busReady.
- 0x00000463 (beq) -> EXECUTE: branch=1, jal=0, aluControl=0000, pcEn=1, regFileWe=0. Then 0x000000EF (jal x1) -> jal=1, RFWDSrcMuxSel=4, regFileWe=1.
- 0xFFFFFFFF -> TRAP after DECODE; illegal=1 and pcEn=0 indefinitely. Assert reset for 1 cycle -> illegal=0, instret=0, instrReq=1.
- Load with busReady held 0 and BUS_TIMEOUT=4 -> TRAP after 4 MEM cycles, no pcEn. Separately, reset asserted mid-MEM_LD -> FETCH next cycle, no regFileWe.
